// File: rtl/xor_descrambler.sv
// Receive-side XOR descrambler: strips an additive Fibonacci LFSR keystream from
// a serial bit stream and packs the recovered bits LSB-first into WIDTH-bit words.
module xor_descrambler #(
  parameter int                    WIDTH    = 8,
  parameter int                    LFSR_LEN = 7,
  parameter logic [LFSR_LEN-1:0]   TAPS     = 7'h60,
  parameter logic [LFSR_LEN-1:0]   SEED     = 7'h7F
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sof,
  output logic             err_sof
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [LFSR_LEN-1:0] lfsr;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    word;
  logic                word_sof;

  logic                accept;
  logic [LFSR_LEN-1:0] s_eff;
  logic                key;
  logic                rec_bit;
  logic [CW-1:0]       pos;
  logic                complete;
  logic [WIDTH-1:0]    word_next;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // Producers hold data stable while valid is high and unaccepted; in_ready only
  // stalls the bit that would complete a word while the output slot is still full.
  assign in_ready = !((cnt == LAST) && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    s_eff     = in_sof ? SEED : lfsr;
    key       = ^(s_eff & TAPS);
    rec_bit   = in_bit ^ key;
    pos       = in_sof ? '0 : cnt;
    complete  = accept && (pos == LAST);
    // A start of frame throws away whatever partial word was being built.
    word_next = in_sof ? '0 : word;
    word_next[pos] = rec_bit;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      lfsr      <= SEED;
      cnt       <= '0;
      word      <= '0;
      word_sof  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      err_sof   <= 1'b0;
    end else begin
      err_sof <= accept && in_sof && (cnt != '0);
      if (accept) begin
        lfsr <= {s_eff[LFSR_LEN-2:0], key};
        word <= word_next;
        cnt  <= complete ? '0 : pos + CW'(1);
        if (pos == '0) word_sof <= in_sof;
      end
      if (complete) begin
        out_valid <= 1'b1;
        out_data  <= word_next;
        out_sof   <= (pos == '0) ? in_sof : word_sof;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed bench for xor_descrambler: framing, keystream, gaps, backpressure,
// mid-word start of frame and asynchronous reset.
module tb_xor_descrambler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetb;
  logic         in_valid;
  logic         in_bit;
  logic         in_sof;
  logic         out_ready;
  logic         in_ready;
  logic         out_valid;
  logic         out_sof;
  logic         err_sof;
  logic [W-1:0] out_data;

  int checks = 0;
  int passes = 0;
  int err_seen = 0;

  xor_descrambler #(.WIDTH(W), .LFSR_LEN(7), .TAPS(7'h60), .SEED(7'h7F)) dut (
    .clk(clk), .resetb(resetb),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err_sof === 1'b1) err_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Called just after a posedge; returns just after the posedge that accepted the bit.
  task automatic send_bit(input logic b, input logic sof, input int maxgap, output int stalls);
    int gap;
    stalls = 0;
    gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(0, 1));
      in_bit   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_bit   = b;
    in_sof   = sof;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, stalls);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] bits, input logic sof, input int maxgap,
                           output int stalls);
    int s;
    stalls = 0;
    for (int i = 0; i < W; i++) begin
      send_bit(bits[i], sof && (i == 0), maxgap, s);
      stalls += s;
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h expected 00", out_data); else passes++;
    checks++; if (out_sof !== 1'b0) $display("FAIL reset_out_sof: got %b expected 0", out_sof); else passes++;
    checks++; if (err_sof !== 1'b0) $display("FAIL reset_err_sof: got %b expected 0", err_sof); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
    resetb = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_frame();
    int s;
    int e0;
    e0 = err_seen;
    out_ready = 1'b1;
    for (int i = 0; i < W - 1; i++) send_bit(1'b0, i == 0, 0, s);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL zero_early_valid: got %b expected 0", out_valid); else passes++;
    @(posedge clk); #1;
    send_bit(1'b0, 1'b0, 0, s);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL zero_latency: got out_valid=%b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 8'h40) $display("FAIL zero_data: got %h expected 40", out_data); else passes++;
    checks++; if (out_sof !== 1'b1) $display("FAIL zero_sof: got %b expected 1", out_sof); else passes++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL zero_drop: got out_valid=%b expected 0", out_valid); else passes++;
    checks++; if (err_seen !== e0) $display("FAIL zero_err: got %0d err pulses expected 0", err_seen - e0); else passes++;
  endtask

  task automatic test_keystream();
    int s;
    out_ready = 1'b1;
    send_word(8'b0100_0000, 1'b1, 0, s);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL key_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 8'h00) $display("FAIL key_data: got %h expected 00", out_data); else passes++;
    checks++; if (out_sof !== 1'b1) $display("FAIL key_sof: got %b expected 1", out_sof); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_gaps();
    int s;
    out_ready = 1'b1;
    send_word(8'h00, 1'b1, 3, s);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL gap_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 8'h40) $display("FAIL gap_data: got %h expected 40", out_data); else passes++;
    checks++; if (out_sof !== 1'b1) $display("FAIL gap_sof: got %b expected 1", out_sof); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int s;
    int total;
    out_ready = 1'b0;
    send_word(8'h00, 1'b1, 0, total);
    for (int i = 0; i < W - 1; i++) begin
      send_bit(1'b0, 1'b0, 0, s);
      total += s;
    end
    checks++; if (total !== 0) $display("FAIL bp_early_stall: got %0d stalls expected 0", total); else passes++;
    in_valid = 1'b1; in_bit = 1'b0; in_sof = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); else passes++;
      checks++; if (out_data !== 8'h40 || out_valid !== 1'b1)
        $display("FAIL bp_hold: got valid=%b data=%h expected 1/40", out_valid, out_data); else passes++;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_comb: got %b expected 1", in_ready); else passes++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL bp_word2_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 8'h30) $display("FAIL bp_word2_data: got %h expected 30", out_data); else passes++;
    checks++; if (out_sof !== 1'b0) $display("FAIL bp_word2_sof: got %b expected 0", out_sof); else passes++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid); else passes++;
  endtask

  task automatic test_sof_mid_word();
    int s;
    int e0;
    out_ready = 1'b1;
    e0 = err_seen;
    send_bit(1'b1, 1'b1, 0, s);
    send_bit(1'b1, 1'b0, 0, s);
    send_bit(1'b1, 1'b0, 0, s);
    send_bit(1'b0, 1'b1, 0, s);
    @(negedge clk);
    checks++; if (err_sof !== 1'b1) $display("FAIL sof_err_pulse: got %b expected 1", err_sof); else passes++;
    @(posedge clk); #1;
    for (int i = 0; i < W - 1; i++) send_bit(1'b0, 1'b0, 0, s);
    @(negedge clk);
    checks++; if (err_seen - e0 !== 1) $display("FAIL sof_err_width: got %0d cycles expected 1", err_seen - e0); else passes++;
    checks++; if (out_valid !== 1'b1) $display("FAIL sof_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 8'h40) $display("FAIL sof_data: got %h expected 40", out_data); else passes++;
    checks++; if (out_sof !== 1'b1) $display("FAIL sof_flag: got %b expected 1", out_sof); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int s;
    out_ready = 1'b0;
    send_word(8'h00, 1'b1, 0, s);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 0, s);
    #2;
    resetb = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_data !== 8'h00) $display("FAIL arst_data: got %h expected 00", out_data); else passes++;
    checks++; if (out_sof !== 1'b0) $display("FAIL arst_sof: got %b expected 0", out_sof); else passes++;
    checks++; if (err_sof !== 1'b0) $display("FAIL arst_err: got %b expected 0", err_sof); else passes++;
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_word(8'h00, 1'b0, 0, s);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL arst_word_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 8'h40) $display("FAIL arst_word_data: got %h expected 40", out_data); else passes++;
    checks++; if (out_sof !== 1'b0) $display("FAIL arst_word_sof: got %b expected 0", out_sof); else passes++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_keystream();
    test_gaps();
    test_back_to_back();
    test_sof_mid_word();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
